// File: rtl/div_sequencer_pkg.sv
// div_sequencer_pkg: alucodes, sequencer states and op decode helpers.
package div_sequencer_pkg;
  localparam logic [4:0] ALU_ADD  = 5'd0;
  localparam logic [4:0] ALU_DIV  = 5'd20;
  localparam logic [4:0] ALU_DIVU = 5'd21;
  localparam logic [4:0] ALU_REM  = 5'd22;
  localparam logic [4:0] ALU_REMU = 5'd23;
  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;
  function automatic logic is_div_op(input logic [4:0] code);
    return code == ALU_DIV || code == ALU_DIVU || code == ALU_REM || code == ALU_REMU;
  endfunction
  function automatic logic is_signed_op(input logic [4:0] code);
    return code == ALU_DIV || code == ALU_REM;
  endfunction
  function automatic logic is_rem_op(input logic [4:0] code);
    return code == ALU_REM || code == ALU_REMU;
  endfunction
endpackage

// File: rtl/div_step.sv
// div_step: one combinational radix-2 restoring divide iteration.
module div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN:0]   rem,
  input  logic [XLEN-1:0] quo,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN:0]   rem_next,
  output logic [XLEN-1:0] quo_next
);
  logic [XLEN:0] sh, trial;
  // the shifted partial remainder is always below 2*divisor, so bit XLEN of trial is its sign
  always_comb begin
    sh       = {rem[XLEN-1:0], quo[XLEN-1]};
    trial    = sh - {1'b0, divisor};
    rem_next = trial[XLEN] ? sh : trial;
    quo_next = {quo[XLEN-2:0], ~trial[XLEN]};
  end
endmodule

// File: rtl/div_sequencer.sv
// div_sequencer: multi-cycle DIV/DIVU/REM/REMU unit with early special-case resolution.
module div_sequencer
  import div_sequencer_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      in_alucode,
  input  logic [XLEN-1:0] in_x,
  input  logic [XLEN-1:0] in_y,
  input  logic            flush,
  output logic            busy,
  output logic            out_valid,
  output logic [XLEN-1:0] out_result
);
  state_t state, nxt;
  logic [CNT_W-1:0] cnt;
  logic [XLEN:0] rem, rem_n;
  logic [XLEN-1:0] quo, quo_n, divisor, ax, ay, spec_res, fin;
  logic is_rem, q_neg, r_neg, sgn, op_rem, accept, y_zero, ovf, special;
  div_step #(.XLEN(XLEN)) u_step (
    .rem(rem), .quo(quo), .divisor(divisor), .rem_next(rem_n), .quo_next(quo_n)
  );
  always_comb begin
    in_ready = state == IDLE && !flush;
    sgn      = is_signed_op(in_alucode);
    op_rem   = is_rem_op(in_alucode);
    accept   = in_valid && in_ready && is_div_op(in_alucode);
    ax       = sgn && in_x[XLEN-1] ? -in_x : in_x;
    ay       = sgn && in_y[XLEN-1] ? -in_y : in_y;
    y_zero   = in_y == '0;
    ovf      = sgn && in_x == {1'b1, {(XLEN-1){1'b0}}} && &in_y;
    special  = y_zero || ovf;
    spec_res = y_zero ? (op_rem ? in_x : '1) : (op_rem ? '0 : in_x);
    fin      = is_rem ? (r_neg ? -rem_n[XLEN-1:0] : rem_n[XLEN-1:0]) : (q_neg ? -quo_n : quo_n);
    nxt      = flush ? IDLE :
               state == IDLE ? (accept ? (special ? DONE : CALC) : IDLE) :
               state == CALC ? (cnt == '0 ? DONE : CALC) : IDLE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      busy       <= 1'b0;
      out_valid  <= 1'b0;
      out_result <= '0;
      cnt        <= '0;
      rem        <= '0;
      quo        <= '0;
      divisor    <= '0;
      is_rem     <= 1'b0;
      q_neg      <= 1'b0;
      r_neg      <= 1'b0;
    end else begin
      state     <= nxt;
      busy      <= nxt != IDLE;
      out_valid <= nxt == DONE;
      if (accept) begin
        cnt     <= CNT_W'(XLEN - 1);
        rem     <= '0;
        quo     <= ax;
        divisor <= ay;
        is_rem  <= op_rem;
        q_neg   <= sgn && (in_x[XLEN-1] ^ in_y[XLEN-1]);
        r_neg   <= sgn && in_x[XLEN-1];
        if (special) out_result <= spec_res;
      end else if (state == CALC) begin
        rem <= rem_n;
        quo <= quo_n;
        cnt <= cnt - 1'b1;
        if (nxt == DONE) out_result <= fin;
      end
    end
  end
endmodule

// File: tb/tb_div_sequencer.sv
// tb_div_sequencer: randomized and directed checks against an arithmetic reference model.
module tb_div_sequencer;
  import div_sequencer_pkg::*;
  localparam int INF = 1 << 30;
  logic clk = 0, rst = 1, in_valid = 0, flush = 0;
  logic [4:0] in_alucode = ALU_ADD;
  logic [31:0] in_x = 0, in_y = 0;
  logic in_ready, busy, out_valid;
  logic [31:0] out_result;
  int cyc = 0, checks = 0, passes = 0;
  int busy_lo = 0, busy_hi = -1, valid_at = INF, acc_cyc = 0;
  logic [31:0] res_prev = 0, res_next = 0;

  div_sequencer #(.XLEN(32), .CNT_W(5)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_alucode(in_alucode),
    .in_x(in_x), .in_y(in_y), .flush(flush), .busy(busy), .out_valid(out_valid),
    .out_result(out_result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a === e) passes++;
    else $display("FAIL %s at cycle %0d: got %h expected %h", n, cyc, a, e);
  endtask

  function automatic logic [31:0] model(input logic [4:0] op, input logic [31:0] x, input logic [31:0] y);
    bit s = op == ALU_DIV || op == ALU_REM;
    bit r = op == ALU_REM || op == ALU_REMU;
    if (y == 0) return r ? x : 32'hFFFF_FFFF;
    if (s && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return r ? 32'h0 : x;
    if (s) return r ? $signed(x) % $signed(y) : $signed(x) / $signed(y);
    return r ? x % y : x / y;
  endfunction

  function automatic int lat(input logic [4:0] op, input logic [31:0] x, input logic [31:0] y);
    bit s = op == ALU_DIV || op == ALU_REM;
    return (y == 0 || (s && x == 32'h8000_0000 && y == 32'hFFFF_FFFF)) ? 1 : 33;
  endfunction

  function automatic bit idle();
    return !(cyc >= busy_lo && cyc <= busy_hi);
  endfunction

  function automatic logic [31:0] cur_res();
    return cyc >= valid_at ? res_next : res_prev;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
    #1;
    chk("busy", busy, idle() ? 0 : 1);
    chk("out_valid", out_valid, cyc == valid_at ? 1 : 0);
    chk("in_ready", in_ready, idle() && !flush ? 1 : 0);
    chk("out_result", out_result, cur_res());
  end

  task automatic wait_idle();
    for (int i = 0; i < 60 && !idle(); i++) @(negedge clk);
    if (!idle()) chk("idle_timeout", 0, 1);
  endtask

  task automatic issue(input logic [4:0] op, input logic [31:0] x, input logic [31:0] y, input bit fl);
    wait_idle();
    in_valid = 1; in_alucode = op; in_x = x; in_y = y; flush = fl;
    if (!fl && (op == ALU_DIV || op == ALU_DIVU || op == ALU_REM || op == ALU_REMU)) begin
      res_prev = cur_res();
      res_next = model(op, x, y);
      acc_cyc = cyc;
      busy_lo = cyc + 1;
      busy_hi = cyc + lat(op, x, y);
      valid_at = busy_hi;
    end
    @(negedge clk);
    in_valid = 0; flush = 0; in_alucode = ALU_ADD;
  endtask

  task automatic do_flush();
    flush = 1;
    if (!idle()) begin
      busy_hi = cyc;
      if (valid_at > cyc) valid_at = INF;
    end
    @(negedge clk);
    flush = 0;
  endtask

  task automatic wait_result(input string n, input logic [31:0] exp_res, input int exp_lat);
    for (int i = 0; i < 40 && !out_valid; i++) @(negedge clk);
    chk({n, "_lat"}, cyc - acc_cyc, exp_lat);
    chk(n, out_result, exp_res);
  endtask

  task automatic run(input string n, input logic [4:0] op, input logic [31:0] x, input logic [31:0] y,
                     input logic [31:0] e, input int l);
    issue(op, x, y, 0);
    wait_result(n, e, l);
  endtask

  initial begin
    chk("m_divu", model(ALU_DIVU, 100, 7), 14);
    chk("m_div_neg", model(ALU_DIV, 32'hFFFF_FFF9, 2), 32'hFFFF_FFFD);
    chk("m_rem_neg", model(ALU_REM, 32'hFFFF_FFF9, 2), 32'hFFFF_FFFF);
    chk("m_ovf", model(ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF), 32'h8000_0000);
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_result", out_result, 0);
    chk("rst_ready", in_ready, 1);
    rst = 0;
    @(negedge clk);
    run("divu_100_7", ALU_DIVU, 100, 7, 14, 33);
    run("remu_100_7", ALU_REMU, 100, 7, 2, 33);
    run("div_m7_2", ALU_DIV, 32'hFFFF_FFF9, 2, 32'hFFFF_FFFD, 33);
    run("rem_m7_2", ALU_REM, 32'hFFFF_FFF9, 2, 32'hFFFF_FFFF, 33);
    run("div_7_m2", ALU_DIV, 7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33);
    run("divu_by0", ALU_DIVU, 5, 0, 32'hFFFF_FFFF, 1);
    run("remu_by0", ALU_REMU, 5, 0, 5, 1);
    run("div_ovf", ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run("rem_ovf", ALU_REM, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1);
    issue(ALU_DIVU, 100, 7, 0);
    repeat (9) @(negedge clk);
    do_flush();
    #1 chk("ready_after_flush", in_ready, 1);
    run("divu_after_flush", ALU_DIVU, 32'hFFFF_FFFF, 32'h10, 32'h0FFF_FFFF, 33);
    issue(ALU_ADD, 9, 3, 0);
    chk("add_ignored", busy, 0);
    issue(ALU_DIV, 9, 3, 1);
    chk("flush_wins", busy, 0);
    issue(ALU_DIVU, 50, 5, 0);
    repeat (32) @(negedge clk);
    chk("in_done", out_valid, 1);
    do_flush();
    issue(ALU_DIV, 1000, 3, 0);
    repeat (5) @(negedge clk);
    #2 rst = 1;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_valid", out_valid, 0);
    chk("arst_result", out_result, 0);
    busy_hi = -1; valid_at = INF; res_prev = 0; res_next = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 0;
    #1 chk("arst_ready", in_ready, 1);
    run("div_m100_7", ALU_DIV, 32'hFFFF_FF9C, 7, 32'hFFFF_FFF2, 33);
    for (int i = 0; i < 40; i++) begin
      logic [4:0] op;
      logic [31:0] x, y;
      int k = $urandom_range(0, 9);
      op = k == 0 ? ALU_ADD : 5'(ALU_DIV + 5'($urandom_range(0, 3)));
      x = $urandom;
      y = $urandom;
      case ($urandom_range(0, 7))
        0: y = 0;
        1: y = $urandom_range(1, 20);
        2: begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
        3: y = -$urandom_range(1, 20);
        default: ;
      endcase
      issue(op, x, y, $urandom_range(0, 15) == 0);
      if ($urandom_range(0, 4) == 0) begin
        repeat ($urandom_range(0, 34)) @(negedge clk);
        do_flush();
      end
    end
    wait_idle();
    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/div_sequencer.md
Name: div_sequencer

Overview:
- Multi-cycle sequencer that takes the M-extension divide/remainder ops (DIV, DIVU, REM, REMU) out of the single-cycle ALU path.
- Runs a radix-2 restoring divide over XLEN cycles.
- Resolves the architectural special cases (divide by zero, signed overflow) early.
- Sits beside the ALU in the execute stage; drives a stall to the pipeline while busy and accepts a flush from branch/exception logic.

Parameters:
- XLEN, 32, operand/result width.
- CNT_W, 5, iteration counter width; must satisfy 2^CNT_W >= XLEN.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  request present.
- in_ready  out  1  sequencer can accept (state IDLE, no flush this cycle).
- in_alucode  in  5  op code, values from 99_define.vh (DIV, DIVU, REM, REMU).
- in_x  in  XLEN  dividend (already muxed r1/pc).
- in_y  in  XLEN  divisor (already muxed r2/imm).
- flush  in  1  synchronous kill of any request in flight.
- busy  out  1  registered; high in CALC and DONE; pipeline stall source.
- out_valid  out  1  one-cycle pulse, result valid.
- out_result  out  XLEN  quotient or remainder; held until next out_valid.

Behaviour:
- Reset (async, any state): state IDLE, busy 0, out_valid 0, out_result 0, counter 0, internal regs 0. in_ready is 1 while in IDLE with flush low.
- Accept: in_valid & in_ready & alucode in {DIV, DIVU, REM, REMU}.
  - in_valid with any other alucode is ignored; no state change.
- Accept cycle latches:
  - op class.
  - Signed flag: DIV/REM.
  - |x| and |y| in signed mode (0x80000000 stays 0x80000000 as unsigned magnitude).
  - Quotient sign = x[31]^y[31] (signed only).
  - Remainder sign = x[31] (signed only).
  - Raw in_x for special cases.
- Special cases, detected at accept: next state DONE, out_valid on the cycle after accept.
  - y==0: DIV/DIVU result 0xFFFFFFFF; REM/REMU result x.
  - Signed x==0x80000000 and y==0xFFFFFFFF: DIV result 0x80000000; REM result 0.
- Normal path, state CALC:
  - Counter loads XLEN-1 and performs one restoring step per cycle: shift {rem,quo} left 1; trial = rem - divisor; if non-negative, keep it and set quo LSB.
  - When counter==0 the step completes and the next state is DONE.
  - XLEN CALC cycles in total; out_valid rises XLEN+1 cycles after the accept cycle (33 for XLEN=32).
- DONE (1 cycle):
  - out_valid=1.
  - out_result = quo or rem, negated if the corresponding sign flag is set.
  - Next state IDLE; busy drops the same edge.
  - No back-to-back accept in DONE; in_ready=0.
- Transitions:
  - IDLE->CALC on normal accept.
  - IDLE->DONE on special accept.
  - CALC->CALC while counter!=0.
  - CALC->DONE at counter==0.
  - DONE->IDLE.
- Flush: in any state, next state IDLE, busy 0 next cycle, no out_valid for the killed op.
  - Flush with in_valid in the same cycle: flush wins, request not accepted (in_ready=0).
  - Flush in DONE: out_valid of that cycle is still asserted; the consumer qualifies it with its own kill.
- Arithmetic: remainder register XLEN+1 bits for the trial subtract. Final negation is two's complement mod 2^XLEN.
- No combinational path from in_* to out_*. in_ready depends only on state and flush.

Decomposition:
- Shared 99_define.vh holds the alucode constants (DIV, DIVU, REM, REMU) and the state encodings IDLE=2'd0, CALC=2'd1, DONE=2'd2.
- One natural sub-module: div_step, a combinational single restoring iteration.
  - Inputs: rem, quo, divisor.
  - Outputs: next rem, next quo.
  - Instantiated once; unit-testable alone.

Test Plan:
- DIVU x=100, y=7 -> out_result 14, out_valid exactly 33 cycles after accept, busy high cycles 1..33. REMU same operands -> 2.
- DIV x=0xFFFFFFF9 (-7), y=2 -> 0xFFFFFFFD (-3). REM same operands -> 0xFFFFFFFF (-1). DIV x=7, y=0xFFFFFFFE -> 0xFFFFFFFD.
- DIVU x=5, y=0 -> 0xFFFFFFFF with out_valid 1 cycle after accept. REMU x=5, y=0 -> 5. DIV x=0x80000000, y=0xFFFFFFFF -> 0x80000000; REM -> 0 (both 1-cycle).
- Flush asserted on the 10th CALC cycle of DIVU 100/7 -> no out_valid, in_ready=1 next cycle. A new DIVU 0xFFFFFFFF/0x10 is then accepted and returns 0x0FFFFFFF after 33 cycles.
- in_valid with ADD alucode while IDLE -> no accept, busy stays 0. in_valid+flush same cycle with a DIV -> not accepted.
- Async rst pulse mid-CALC (not clock-aligned) -> busy, out_valid, out_result go 0 immediately. in_ready=1 after release. Next DIV 0xFFFFFF9C (-100)/7 -> 0xFFFFFFF2 (-14).
